ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported 2 KiB byte RAM. Requester 0 (instruction fetch) and requester 1 (load/store unit) each issue byte or halfword reads and writes through a req/ack handshake. The arbiter grants one requester at a time, drives the RAM command for exactly one cycle, and returns registered read data with a one-cycle ack. It also rejects out-of-range accesses without touching the RAM.

---
 rtl/ram_arbiter.sv | 90 +++++++++
 tb/tb_ram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter/sequencer for a 2 KiB byte RAM with range fault check.
// RAM_ARB_RR_EN selects round-robin tie-break; otherwise requester 1 has fixed priority.
module ram_arbiter (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req0,
  input  logic        I_req1,
  input  logic [15:0] I_addr0,
  input  logic [15:0] I_addr1,
  input  logic [1:0]  I_size0,
  input  logic [1:0]  I_size1,
  input  logic        I_write0,
  input  logic        I_write1,
  input  logic [15:0] I_data0,
  input  logic [15:0] I_data1,
  output logic        O_ack0,
  output logic        O_ack1,
  output logic [15:0] O_rdata,
  output logic        O_fault,
  output logic        O_ram_enable,
  output logic        O_ram_write,
  output logic [1:0]  O_ram_size,
  output logic [15:0] O_ram_addr,
  output logic [15:0] O_ram_data,
  input  logic [15:0] I_ram_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
  state_t r_state, w_next;
  logic r_last, r_gnt, r_write, r_fault;
  logic [1:0] r_size;
  logic [15:0] r_addr, r_data, r_rdata;
  logic w_tie1, w_pick1, w_grant, w_fault;
  logic [15:0] w_addr;
  logic [1:0] w_size;
`ifdef RAM_ARB_RR_EN
  assign w_tie1 = ~r_last;
`else
  // last-grant is still tracked but never steers the fixed-priority decision
  assign w_tie1 = 1'b1 | r_last;
`endif
  assign w_grant = I_req0 | I_req1;
  assign w_pick1 = I_req1 & (~I_req0 | w_tie1);
  assign w_addr = w_pick1 ? I_addr1 : I_addr0;
  assign w_size = w_pick1 ? I_size1 : I_size0;
  assign w_fault = (w_addr[15:11] != 5'd0) | (w_size == 2'd2 && w_addr == 16'h07FF);
  assign O_rdata = r_rdata;
  assign O_ram_write = r_write;
  assign O_ram_size = r_size;
  assign O_ram_addr = r_addr;
  assign O_ram_data = r_data;
  always_comb begin
    w_next = IDLE;
    O_ram_enable = r_state == ISSUE;
    O_ack0 = r_state == ACK && !r_gnt;
    O_ack1 = r_state == ACK && r_gnt;
    O_fault = r_state == ACK && r_fault;
    unique case (r_state)
      IDLE:    w_next = w_grant ? (w_fault ? ACK : ISSUE) : IDLE;
      ISSUE:   w_next = r_write ? ACK : CAPTURE;
      CAPTURE: w_next = ACK;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      r_state <= IDLE;
      r_last <= 1'b0;
      r_gnt <= 1'b0;
      r_write <= 1'b0;
      r_fault <= 1'b0;
      r_size <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant) begin
        r_gnt <= w_pick1;
        r_addr <= w_addr;
        r_size <= w_size;
        r_write <= w_pick1 ? I_write1 : I_write0;
        r_data <= w_pick1 ? I_data1 : I_data0;
        r_fault <= w_fault;
        r_rdata <= '0;
      end
      if (r_state == CAPTURE) r_rdata <= r_size == 2'd2 ? I_ram_data : {8'h00, I_ram_data[7:0]};
      if (r_state == ACK) r_last <= r_gnt;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized bench for ram_arbiter against a latency/memory reference model.
module tb_ram_arbiter;
  logic I_clk = 0, I_reset = 1, I_req0 = 0, I_req1 = 0, I_write0 = 0, I_write1 = 0;
  logic [15:0] I_addr0 = '0, I_addr1 = '0, I_data0 = '0, I_data1 = '0, I_ram_data = '0;
  logic [1:0] I_size0 = '0, I_size1 = '0;
  logic O_ack0, O_ack1, O_fault, O_ram_enable, O_ram_write;
  logic [1:0] O_ram_size;
  logic [15:0] O_rdata, O_ram_addr, O_ram_data;
  int cyc = 0, n_chk = 0, n_fail = 0;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic [7:0] ram [2048];
  logic [7:0] ref_mem [2048];
  int next_idle = 0, ack_cyc = -1, en_cyc = -1;
  logic m_last = 0, m_gnt = 0, m_fault = 0, m_w = 0;
  logic [15:0] m_rd = '0, e_addr = '0, e_data = '0;
  logic [1:0] e_size = '0;

  ram_arbiter dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_req0(I_req0), .I_req1(I_req1),
    .I_addr0(I_addr0), .I_addr1(I_addr1), .I_size0(I_size0), .I_size1(I_size1),
    .I_write0(I_write0), .I_write1(I_write1), .I_data0(I_data0), .I_data1(I_data1),
    .O_ack0(O_ack0), .O_ack1(O_ack1), .O_rdata(O_rdata), .O_fault(O_fault),
    .O_ram_enable(O_ram_enable), .O_ram_write(O_ram_write), .O_ram_size(O_ram_size),
    .O_ram_addr(O_ram_addr), .O_ram_data(O_ram_data), .I_ram_data(I_ram_data)
  );

  always #5 I_clk = ~I_clk;
  always @(posedge I_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // RAM: samples the command on the edge ending ISSUE, read data valid the next cycle
  initial begin
    logic [10:0] ra;
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i * 37 + 5);
    forever begin
      @(posedge I_clk);
      ra = O_ram_addr[10:0];
      if (O_ram_enable && O_ram_write) begin
        ram[ra] = O_ram_data[7:0];
        if (O_ram_size == 2'd2) ram[ra + 11'd1] = O_ram_data[15:8];
      end else if (O_ram_enable) I_ram_data <= {ram[ra + 11'd1], ram[ra]};
    end
  end

  // reference model: each transaction decided in an idle cycle completes after a fixed latency
  initial begin
    logic g, w, hw;
    logic [15:0] a, d;
    logic [1:0] s;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i * 37 + 5);
    forever begin
      @(negedge I_clk);
      if (I_reset) begin
        next_idle = cyc + 1; ack_cyc = -1; en_cyc = -1; m_last = 0;
        chk("reset_outputs", 64'({O_ack0, O_ack1, O_fault, O_ram_enable, O_ram_write, O_ram_size, O_ram_addr, O_ram_data, O_rdata}), 64'd0);
      end else begin
        if (cyc == next_idle) begin
          if (I_req0 || I_req1) begin
            g = (I_req0 && I_req1) ? (RR ? !m_last : 1'b1) : I_req1;
            a = g ? I_addr1 : I_addr0;
            s = g ? I_size1 : I_size0;
            w = g ? I_write1 : I_write0;
            d = g ? I_data1 : I_data0;
            hw = s == 2'd2;
            m_fault = a[15:11] != 0 || (hw && a == 16'h07FF);
            ack_cyc = cyc + (m_fault ? 1 : w ? 2 : 3);
            en_cyc = m_fault ? -1 : cyc + 1;
            next_idle = ack_cyc + 1;
            m_gnt = g; m_w = w; m_last = g;
            e_addr = a; e_size = s; e_data = d;
            m_rd = (m_fault || w) ? 16'h0 : {hw ? ref_mem[a[10:0] + 11'd1] : 8'h00, ref_mem[a[10:0]]};
            if (!m_fault && w) begin
              ref_mem[a[10:0]] = d[7:0];
              if (hw) ref_mem[a[10:0] + 11'd1] = d[15:8];
            end
          end else next_idle = cyc + 1;
        end
        chk("ack0", 64'(O_ack0), 64'(cyc == ack_cyc && !m_gnt));
        chk("ack1", 64'(O_ack1), 64'(cyc == ack_cyc && m_gnt));
        chk("ram_enable", 64'(O_ram_enable), 64'(cyc == en_cyc));
        if (cyc == ack_cyc) begin
          chk("fault", 64'(O_fault), 64'(m_fault));
          if (m_fault || !m_w) chk("rdata", 64'(O_rdata), 64'(m_rd));
        end
        if (cyc == en_cyc)
          chk("ram_cmd", 64'({O_ram_write, O_ram_size, O_ram_addr, O_ram_data}), 64'({m_w, e_size, e_addr, e_data}));
      end
    end
  end

  task automatic set_cmd(input bit r, input bit q, input logic [15:0] a, input logic [1:0] s, input bit w, input logic [15:0] d);
    if (r) begin I_req1 = q; I_addr1 = a; I_size1 = s; I_write1 = w; I_data1 = d; end
    else begin I_req0 = q; I_addr0 = a; I_size0 = s; I_write0 = w; I_data0 = d; end
  endtask

  task automatic rnd_cmd(input bit r);
    int k;
    logic [15:0] a;
    k = $urandom_range(0, 9);
    a = k < 7 ? 16'($urandom_range(0, 63)) : k == 7 ? 16'h07FF : k == 8 ? 16'h07FE : {5'($urandom_range(1, 31)), 11'($urandom)};
    set_cmd(r, 1, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  task automatic wait_ack(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge I_clk);
      if (O_ack0 || O_ack1) begin who = O_ack1 ? 1 : 0; break; end
    end
    @(posedge I_clk); #1;
  endtask

  task automatic xact(input bit r, input logic [15:0] a, input logic [1:0] s, input bit w, input logic [15:0] d,
                      output int lat, output logic [15:0] rd, output logic f, output int ens);
    int t0;
    set_cmd(r, 1, a, s, w, d);
    t0 = cyc; lat = -1; ens = 0; rd = '0; f = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge I_clk);
      ens += int'(O_ram_enable);
      if (r ? O_ack1 : O_ack0) begin lat = cyc - t0; rd = O_rdata; f = O_fault; break; end
    end
    @(posedge I_clk); #1;
    if (r) I_req1 = 0; else I_req0 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic a0, a1, f;
    logic [15:0] rd;
    logic [3:0] order;
    int lat, ens, who;
    repeat (3) @(posedge I_clk);
    #1 I_reset = 0;
    set_cmd(0, 1, 16'h0020, 2'd2, 0, 16'h0);
    set_cmd(1, 1, 16'h0030, 2'd2, 0, 16'h0);
    order = '0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who);
      order[i] = who == 1;
    end
    I_req1 = 0;
    wait_ack(who);
    I_req0 = 0;
    chk("grant_order", 64'(order), 64'(RR ? 4'b0101 : 4'b1111));
    chk("starve_release", 64'(who), 64'd0);
    xact(1, 16'h0010, 2'd2, 1, 16'hBEEF, lat, rd, f, ens);
    chk("wr_lat", 64'(lat), 64'd2);
    chk("wr_ens", 64'(ens), 64'd1);
    xact(1, 16'h0010, 2'd2, 0, 16'h0, lat, rd, f, ens);
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_data", 64'(rd), 64'hBEEF);
    chk("rd_ens", 64'(ens), 64'd1);
    xact(0, 16'h0011, 2'd1, 0, 16'h0, lat, rd, f, ens);
    chk("byte_data", 64'(rd), 64'h00BE);
    chk("byte_fault", 64'(f), 64'd0);
    xact(0, 16'h0800, 2'd1, 0, 16'h0, lat, rd, f, ens);
    chk("oor_lat", 64'(lat), 64'd1);
    chk("oor_resp", 64'({f, rd}), 64'h10000);
    chk("oor_ens", 64'(ens), 64'd0);
    xact(1, 16'h07FF, 2'd2, 0, 16'h0, lat, rd, f, ens);
    chk("hw_edge_lat", 64'(lat), 64'd1);
    chk("hw_edge_resp", 64'({f, rd}), 64'h10000);
    chk("hw_edge_ens", 64'(ens), 64'd0);
    xact(0, 16'h07FF, 2'd1, 0, 16'h0, lat, rd, f, ens);
    chk("byte_edge_lat", 64'(lat), 64'd3);
    chk("byte_edge_resp", 64'({f, rd}), 64'h000E0);
    set_cmd(1, 1, 16'h0010, 2'd2, 0, 16'h0);
    @(posedge I_clk); #1;
    @(posedge I_clk); #1;
    I_reset = 1;
    #1 chk("reset_async", 64'({O_ack0, O_ack1, O_fault, O_ram_enable, O_ram_write, O_ram_size, O_ram_addr, O_ram_data, O_rdata}), 64'd0);
    I_req1 = 0;
    repeat (2) @(posedge I_clk);
    #1 I_reset = 0;
    @(posedge I_clk); #1;
    xact(1, 16'h0010, 2'd2, 0, 16'h0, lat, rd, f, ens);
    chk("post_reset_lat", 64'(lat), 64'd3);
    chk("post_reset_data", 64'(rd), 64'hBEEF);
    for (int c = 0; c < 600; c++) begin
      @(negedge I_clk); a0 = O_ack0; a1 = O_ack1;
      @(posedge I_clk); #1;
      if (!I_req0 || a0) begin if ($urandom_range(0, 2) != 0) rnd_cmd(0); else I_req0 = 0; end
      if (!I_req1 || a1) begin if ($urandom_range(0, 2) != 0) rnd_cmd(1); else I_req1 = 0; end
    end
    for (int c = 0; c < 30 && (I_req0 || I_req1); c++) begin
      @(negedge I_clk); a0 = O_ack0; a1 = O_ack1;
      @(posedge I_clk); #1;
      if (a0) I_req0 = 0;
      if (a1) I_req1 = 0;
    end
    chk("drain", 64'({I_req0, I_req1}), 64'd0);
    repeat (3) @(posedge I_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
